// File: rtl/rx_ram_arbiter_pkg.sv
// Shared types and constants for the UART RX to RAM arbiter.
package rx_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CPU  = 2'd1,
    ST_DMA  = 2'd2
  } arb_state_t;

  typedef enum logic {
    LAST_CPU = 1'b0,
    LAST_DMA = 1'b1
  } arb_last_t;

  localparam logic [31:0] DEF_ADR_LL = 32'h00C0_0000;
  localparam logic [31:0] DEF_ADR_UL = 32'h00C1_0000;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  // Next word address inside [lo, hi), wrapping back to lo at the end.
  function automatic logic [31:0] next_word_adr(input logic [31:0] adr,
                                                input logic [31:0] lo,
                                                input logic [31:0] hi);
    logic [31:0] nxt;
    nxt = adr + WORD_BYTES;
    return (nxt == hi) ? lo : nxt;
  endfunction

endpackage

// File: rtl/rx_byte_fifo.sv
// Byte FIFO with first-word fall-through head; a push while full is
// accepted only when a pop frees a slot in the same cycle.
module rx_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [7:0]               i_din,
  input  logic                     i_pop,
  output logic [7:0]               o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign o_empty = (o_level == '0);
  assign o_full  = (o_level == FULL_LEVEL);
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);
  assign o_head  = mem[rd_ptr];

  // Storage needs no reset; only pointers and level define validity.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_din;
  end

  // Pointers and occupancy; simultaneous push and pop leave level unchanged.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      o_level <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   o_level <= o_level + (AW+1)'(1);
        2'b01:   o_level <= o_level - (AW+1)'(1);
        default: o_level <= o_level;
      endcase
    end
  end

endmodule

// File: rtl/rx_ram_arbiter.sv
// Shares one wishbone RAM port between the CPU and a DMA path that drains
// received UART bytes into a word-per-byte ring buffer.
//
// state | meaning
// IDLE  | no grant; decide next owner (one cycle between every transaction)
// CPU   | CPU owns the RAM port until i_mem_ack
// DMA   | FIFO head written to o_wr_adr until i_mem_ack
module rx_ram_arbiter
  import rx_ram_arbiter_pkg::*;
#(
  parameter logic [31:0] ADR_LL     = DEF_ADR_LL,
  parameter logic [31:0] ADR_UL     = DEF_ADR_UL,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                          i_wb_clk,
  input  logic                          i_wb_rst,
  input  logic                          i_rx_done,
  input  logic [7:0]                    i_rx_byte,
  input  logic [31:0]                   i_cpu_adr,
  input  logic [31:0]                   i_cpu_dat,
  input  logic [3:0]                    i_cpu_sel,
  input  logic                          i_cpu_we,
  input  logic                          i_cpu_cyc,
  output logic [31:0]                   o_cpu_rdt,
  output logic                          o_cpu_ack,
  output logic [31:0]                   o_mem_adr,
  output logic [31:0]                   o_mem_dat,
  output logic [3:0]                    o_mem_sel,
  output logic                          o_mem_we,
  output logic                          o_mem_cyc,
  input  logic [31:0]                   i_mem_rdt,
  input  logic                          i_mem_ack,
  output logic [31:0]                   o_wr_adr,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_overflow,
  input  logic                          i_ovf_clr
);

  arb_state_t state;
  arb_last_t  last;
  logic [7:0] fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;

  // The FIFO head is consumed only when the RAM acknowledges its write.
  assign fifo_pop = (state == ST_DMA) && i_mem_ack;

  rx_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_wb_clk),
    .i_rst   (i_wb_rst),
    .i_push  (i_rx_done),
    .i_din   (i_rx_byte),
    .i_pop   (fifo_pop),
    .o_head  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (o_fifo_level)
  );

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst)                                  o_overflow <= 1'b0;
    else if (i_rx_done && fifo_full && !fifo_pop)  o_overflow <= 1'b1;
    else if (i_ovf_clr)                            o_overflow <= 1'b0;
  end

  // Grant FSM with round-robin memory and the ring-buffer write pointer.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      state    <= ST_IDLE;
      last     <= LAST_DMA;
      o_wr_adr <= ADR_LL;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_cpu_cyc && (fifo_empty || last == LAST_DMA)) state <= ST_CPU;
          else if (!fifo_empty)                              state <= ST_DMA;
        end
        ST_CPU: begin
          if (i_mem_ack) begin
            state <= ST_IDLE;
            last  <= LAST_CPU;
          end
        end
        ST_DMA: begin
          if (i_mem_ack) begin
            state    <= ST_IDLE;
            last     <= LAST_DMA;
            o_wr_adr <= next_word_adr(o_wr_adr, ADR_LL, ADR_UL);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RAM port mux decoded from the registered state; CPU fields pass through
  // whenever DMA does not own the bus.
  always_comb begin
    o_mem_adr = i_cpu_adr;
    o_mem_dat = i_cpu_dat;
    o_mem_sel = i_cpu_sel;
    o_mem_we  = 1'b0;
    o_mem_cyc = 1'b0;
    case (state)
      ST_CPU: begin
        o_mem_we  = i_cpu_we;
        o_mem_cyc = i_cpu_cyc;
      end
      ST_DMA: begin
        o_mem_adr = o_wr_adr;
        o_mem_dat = {24'b0, fifo_head};
        o_mem_sel = 4'b1111;
        o_mem_we  = 1'b1;
        o_mem_cyc = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_cpu_ack = (state == ST_CPU) && i_mem_ack;
  assign o_cpu_rdt = i_mem_rdt;

endmodule

// File: tb/tb_rx_ram_arbiter.sv
// Scoreboard bench: expected RAM transactions are queued as stimulus is
// driven and checked when the bench RAM slave acknowledges them.
module tb_rx_ram_arbiter;

  localparam logic [31:0] LL   = 32'h00C0_0000;
  localparam logic [31:0] UL   = 32'h00C1_0000;
  localparam logic [31:0] UL_W = 32'h00C0_0008;
  localparam logic [31:0] RDT  = 32'h1234_5678;

  logic        i_wb_clk, i_wb_rst, rx_done, cpu_we, cpu_cyc, mem_ack, ovf_clr;
  logic [7:0]  rx_byte;
  logic [31:0] cpu_adr, cpu_dat, mem_rdt;
  logic [3:0]  cpu_sel;

  logic [31:0] o_cpu_rdt, o_mem_adr, o_mem_dat, o_wr_adr;
  logic [3:0]  o_mem_sel;
  logic        o_cpu_ack, o_mem_we, o_mem_cyc, o_overflow;
  logic [2:0]  o_fifo_level;

  logic [31:0] w_cpu_rdt, w_mem_adr, w_mem_dat, w_wr_adr;
  logic [3:0]  w_mem_sel;
  logic        w_cpu_ack, w_mem_we, w_mem_cyc, w_overflow;
  logic [2:0]  w_fifo_level;

  typedef struct {
    logic        is_cpu;
    logic [31:0] adr;
    logic [31:0] adr_w;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } txn_t;

  txn_t        sb[$];
  txn_t        rsp_e;
  logic        rsp_exp_ack;
  logic [31:0] exp_ptr, exp_ptr_w;
  int          n_checks, n_errors, cpu_acks;
  bit          ack_en;

  rx_ram_arbiter dut (
    .i_wb_clk(i_wb_clk), .i_wb_rst(i_wb_rst), .i_rx_done(rx_done), .i_rx_byte(rx_byte),
    .i_cpu_adr(cpu_adr), .i_cpu_dat(cpu_dat), .i_cpu_sel(cpu_sel), .i_cpu_we(cpu_we),
    .i_cpu_cyc(cpu_cyc), .o_cpu_rdt(o_cpu_rdt), .o_cpu_ack(o_cpu_ack),
    .o_mem_adr(o_mem_adr), .o_mem_dat(o_mem_dat), .o_mem_sel(o_mem_sel), .o_mem_we(o_mem_we),
    .o_mem_cyc(o_mem_cyc), .i_mem_rdt(mem_rdt), .i_mem_ack(mem_ack), .o_wr_adr(o_wr_adr),
    .o_fifo_level(o_fifo_level), .o_overflow(o_overflow), .i_ovf_clr(ovf_clr)
  );

  rx_ram_arbiter #(.ADR_LL(LL), .ADR_UL(UL_W), .FIFO_DEPTH(4)) dut_w (
    .i_wb_clk(i_wb_clk), .i_wb_rst(i_wb_rst), .i_rx_done(rx_done), .i_rx_byte(rx_byte),
    .i_cpu_adr(cpu_adr), .i_cpu_dat(cpu_dat), .i_cpu_sel(cpu_sel), .i_cpu_we(cpu_we),
    .i_cpu_cyc(cpu_cyc), .o_cpu_rdt(w_cpu_rdt), .o_cpu_ack(w_cpu_ack),
    .o_mem_adr(w_mem_adr), .o_mem_dat(w_mem_dat), .o_mem_sel(w_mem_sel), .o_mem_we(w_mem_we),
    .o_mem_cyc(w_mem_cyc), .i_mem_rdt(mem_rdt), .i_mem_ack(mem_ack), .o_wr_adr(w_wr_adr),
    .o_fifo_level(w_fifo_level), .o_overflow(w_overflow), .i_ovf_clr(ovf_clr)
  );

  initial begin
    i_wb_clk = 1'b0;
    forever #5 i_wb_clk = ~i_wb_clk;
  end

  // RAM slave: acks one cycle after seeing cyc, checks each transaction.
  initial begin
    mem_ack = 1'b0;
    forever begin
      @(negedge i_wb_clk);
      if (mem_ack) mem_ack = 1'b0;
      else if (o_mem_cyc && ack_en && !i_wb_rst) begin
        rsp_exp_ack = 1'b0;
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_txn adr=%h dat=%h", o_mem_adr, o_mem_dat);
        end else begin
          rsp_e = sb.pop_front();
          rsp_exp_ack = rsp_e.is_cpu;
          if ({o_mem_adr, o_mem_dat, o_mem_sel, o_mem_we} !==
              {rsp_e.adr, rsp_e.dat, rsp_e.sel, rsp_e.we}) begin
            n_errors++;
            $display("FAIL txn got adr=%h dat=%h sel=%h we=%b exp adr=%h dat=%h sel=%h we=%b",
                     o_mem_adr, o_mem_dat, o_mem_sel, o_mem_we,
                     rsp_e.adr, rsp_e.dat, rsp_e.sel, rsp_e.we);
          end
          n_checks++;
          if (w_mem_adr !== rsp_e.adr_w) begin
            n_errors++;
            $display("FAIL wrap_adr got=%h exp=%h", w_mem_adr, rsp_e.adr_w);
          end
        end
        mem_ack = 1'b1;
        #1;
        n_checks++;
        if (o_cpu_ack !== rsp_exp_ack) begin
          n_errors++;
          $display("FAIL cpu_ack got=%b exp=%b", o_cpu_ack, rsp_exp_ack);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_wb_clk);
    #1;
  endtask

  task automatic push_dma_exp(input logic [7:0] b);
    txn_t t;
    t = '{is_cpu: 1'b0, adr: exp_ptr, adr_w: exp_ptr_w, dat: {24'b0, b}, sel: 4'hF, we: 1'b1};
    sb.push_back(t);
    exp_ptr   = (exp_ptr + 32'd4 == UL) ? LL : exp_ptr + 32'd4;
    exp_ptr_w = (exp_ptr_w + 32'd4 == UL_W) ? LL : exp_ptr_w + 32'd4;
  endtask

  task automatic push_cpu_exp(input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t = '{is_cpu: 1'b1, adr: a, adr_w: a, dat: d, sel: 4'h3, we: 1'b1};
    sb.push_back(t);
  endtask

  task automatic strobe(input logic [7:0] b);
    rx_byte = b;
    rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while ((sb.size() != 0 || o_mem_cyc) && k < budget) begin
      tick(1);
      k++;
    end
    n_checks++;
    if (k >= budget) begin
      n_errors++;
      $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
    end
  endtask

  task automatic do_reset();
    i_wb_rst = 1'b1;
    rx_done = 1'b0; cpu_cyc = 1'b0; cpu_we = 1'b0; ovf_clr = 1'b0; ack_en = 1'b0;
    sb.delete();
    exp_ptr = LL; exp_ptr_w = LL;
    tick(2);
    i_wb_rst = 1'b0;
  endtask

  task automatic test_reset();
    i_wb_rst = 1'b1;
    tick(2);
    n_checks += 5;
    if (o_mem_cyc !== 1'b0)    begin n_errors++; $display("FAIL rst_cyc got=%b exp=0", o_mem_cyc); end
    if (o_cpu_ack !== 1'b0)    begin n_errors++; $display("FAIL rst_ack got=%b exp=0", o_cpu_ack); end
    if (o_wr_adr !== LL)       begin n_errors++; $display("FAIL rst_wr_adr got=%h exp=%h", o_wr_adr, LL); end
    if (o_fifo_level !== 3'd0) begin n_errors++; $display("FAIL rst_level got=%0d exp=0", o_fifo_level); end
    if (o_overflow !== 1'b0)   begin n_errors++; $display("FAIL rst_ovf got=%b exp=0", o_overflow); end
    do_reset();
  endtask

  task automatic test_single_byte();
    ack_en = 1'b1;
    push_dma_exp(8'h5A);
    strobe(8'h5A);
    n_checks += 2;
    if (o_fifo_level !== 3'd1) begin n_errors++; $display("FAIL lat_level got=%0d exp=1", o_fifo_level); end
    if (o_mem_cyc !== 1'b0)    begin n_errors++; $display("FAIL lat_idle_cyc got=%b exp=0", o_mem_cyc); end
    tick(1);
    n_checks++;
    if (o_mem_cyc !== 1'b1)    begin n_errors++; $display("FAIL lat_dma_cyc got=%b exp=1", o_mem_cyc); end
    wait_drain(20);
    n_checks += 3;
    if (o_wr_adr !== LL + 32'd4) begin n_errors++; $display("FAIL single_wr_adr got=%h exp=%h", o_wr_adr, LL + 32'd4); end
    if (w_wr_adr !== LL + 32'd4) begin n_errors++; $display("FAIL single_wr_adr_w got=%h exp=%h", w_wr_adr, LL + 32'd4); end
    if (o_fifo_level !== 3'd0)   begin n_errors++; $display("FAIL single_level got=%0d exp=0", o_fifo_level); end
  endtask

  task automatic cpu_master();
    int w;
    for (int k = 0; k < 3; k++) begin
      for (w = 0; w < 60; w++) begin
        @(negedge i_wb_clk);
        #2;
        if (o_cpu_ack) break;
      end
      if (w >= 60) begin
        n_checks++; n_errors++;
        $display("FAIL cpu_ack_timeout txn=%0d", k);
        cpu_cyc = 1'b0;
        return;
      end
      cpu_acks++;
      if (k == 0) begin
        n_checks++;
        if (o_cpu_rdt !== RDT) begin n_errors++; $display("FAIL cpu_rdt got=%h exp=%h", o_cpu_rdt, RDT); end
      end
      tick(1);
      if (k < 2) begin
        cpu_adr = 32'h1000 + 32'(4 * (k + 1));
        cpu_dat = 32'hA0 + 32'(k + 1);
      end else begin
        cpu_cyc = 1'b0;
        cpu_we  = 1'b0;
      end
    end
  endtask

  task automatic test_contention();
    ack_en = 1'b0;
    cpu_acks = 0;
    mem_rdt = RDT;
    cpu_adr = 32'h1000; cpu_dat = 32'hA0; cpu_sel = 4'h3; cpu_we = 1'b1;
    push_cpu_exp(32'h1000, 32'hA0);
    push_dma_exp(8'h11);
    push_cpu_exp(32'h1004, 32'hA1);
    push_dma_exp(8'h22);
    push_cpu_exp(32'h1008, 32'hA2);
    push_dma_exp(8'h33);
    cpu_cyc = 1'b1;
    strobe(8'h11);
    strobe(8'h22);
    strobe(8'h33);
    ack_en = 1'b1;
    fork
      cpu_master();
      wait_drain(200);
    join
    n_checks++;
    if (cpu_acks !== 3) begin n_errors++; $display("FAIL cpu_ack_count got=%0d exp=3", cpu_acks); end
  endtask

  task automatic test_wrap();
    do_reset();
    ack_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_dma_exp(8'hB0 + 8'(i));
      strobe(8'hB0 + 8'(i));
    end
    wait_drain(60);
    n_checks += 2;
    if (w_wr_adr !== LL + 32'd4)  begin n_errors++; $display("FAIL wrap_ptr got=%h exp=%h", w_wr_adr, LL + 32'd4); end
    if (o_wr_adr !== LL + 32'hC)  begin n_errors++; $display("FAIL main_ptr got=%h exp=%h", o_wr_adr, LL + 32'hC); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) push_dma_exp(8'hC0 + 8'(i));
      strobe(8'hC0 + 8'(i));
    end
    n_checks += 2;
    if (o_fifo_level !== 3'd4) begin n_errors++; $display("FAIL ovf_level got=%0d exp=4", o_fifo_level); end
    if (o_overflow !== 1'b1)   begin n_errors++; $display("FAIL ovf_set got=%b exp=1", o_overflow); end
    ovf_clr = 1'b1;
    strobe(8'hC6);
    ovf_clr = 1'b0;
    n_checks += 2;
    if (o_overflow !== 1'b1)   begin n_errors++; $display("FAIL ovf_set_wins got=%b exp=1", o_overflow); end
    if (o_fifo_level !== 3'd4) begin n_errors++; $display("FAIL ovf_level7 got=%0d exp=4", o_fifo_level); end
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    n_checks++;
    if (o_overflow !== 1'b0)   begin n_errors++; $display("FAIL ovf_clear got=%b exp=0", o_overflow); end
  endtask

  task automatic test_full_push_pop();
    ack_en = 1'b1;
    @(negedge i_wb_clk);
    #2;
    ack_en = 1'b0;
    push_dma_exp(8'hC9);
    strobe(8'hC9);
    n_checks += 2;
    if (o_fifo_level !== 3'd4) begin n_errors++; $display("FAIL pp_level got=%0d exp=4", o_fifo_level); end
    if (o_overflow !== 1'b0)   begin n_errors++; $display("FAIL pp_ovf got=%b exp=0", o_overflow); end
    ack_en = 1'b1;
    wait_drain(100);
    n_checks += 2;
    if (o_fifo_level !== 3'd0) begin n_errors++; $display("FAIL pp_drain_level got=%0d exp=0", o_fifo_level); end
    if (o_wr_adr !== LL + 32'h14) begin n_errors++; $display("FAIL pp_ptr got=%h exp=%h", o_wr_adr, LL + 32'h14); end
  endtask

  task automatic test_reset_mid_dma();
    do_reset();
    ack_en = 1'b1;
    push_dma_exp(8'h77);
    strobe(8'h77);
    wait_drain(20);
    ack_en = 1'b0;
    strobe(8'h88);
    tick(1);
    n_checks++;
    if (o_mem_cyc !== 1'b1) begin n_errors++; $display("FAIL mid_pre_cyc got=%b exp=1", o_mem_cyc); end
    i_wb_rst = 1'b1;
    #1;
    n_checks += 4;
    if (o_mem_cyc !== 1'b0)    begin n_errors++; $display("FAIL mid_cyc got=%b exp=0", o_mem_cyc); end
    if (o_wr_adr !== LL)       begin n_errors++; $display("FAIL mid_wr_adr got=%h exp=%h", o_wr_adr, LL); end
    if (o_fifo_level !== 3'd0) begin n_errors++; $display("FAIL mid_level got=%0d exp=0", o_fifo_level); end
    if (o_cpu_ack !== 1'b0)    begin n_errors++; $display("FAIL mid_ack got=%b exp=0", o_cpu_ack); end
    tick(1);
    i_wb_rst = 1'b0;
    exp_ptr = LL; exp_ptr_w = LL;
    ack_en = 1'b1;
    tick(10);
    n_checks++;
    if (o_mem_cyc !== 1'b0) begin n_errors++; $display("FAIL mid_after_cyc got=%b exp=0", o_mem_cyc); end
  endtask

  initial begin
    n_checks = 0; n_errors = 0; cpu_acks = 0;
    rx_done = 1'b0; rx_byte = 8'h00; ovf_clr = 1'b0; ack_en = 1'b0;
    cpu_adr = '0; cpu_dat = '0; cpu_sel = 4'h0; cpu_we = 1'b0; cpu_cyc = 1'b0;
    mem_rdt = RDT; exp_ptr = LL; exp_ptr_w = LL;
    test_reset();
    test_single_byte();
    test_contention();
    test_wrap();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_dma();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
